fpa_scheduler: RTL



---
 rtl/fpa_sched_pkg.sv | 29 ++
 rtl/fpa.sv | 76 +++++++
 rtl/fpa_scheduler_rr_arbiter.sv | 36 +++
 rtl/fpa_scheduler.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fpa_sched_pkg.sv
// Shared types and widths for the FP adder scheduler: slot states and pipeline stage records.
package fpa_sched_pkg;

    localparam int FP_W      = 32;
    localparam int STAT_W    = 16;
    // Widest requester tag the stage records carry (NREQ up to 8).
    localparam int TAG_MAX_W = 3;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_BUSY = 2'd1,
        SLOT_DONE = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [FP_W-1:0]      a;
        logic [FP_W-1:0]      b;
    } s1_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [FP_W-1:0]      sum;
        logic                 of;
    } s2_t;

endpackage

// File: rtl/fpa.sv
// Combinational single-precision adder, round-to-nearest-even; zero/subnormal inputs and
// underflowing results are flushed to zero, exponent overflow returns infinity with of_o set.
module fpa
    import fpa_sched_pkg::*;
(
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic [FP_W-1:0] sum_o,
    output logic            of_o
);
    logic [FP_W-1:0]   x, y;
    logic [7:0]        ex, ey, d_exp;
    logic [26:0]       mx, my, my_sh, nrm;
    logic [27:0]       raw;
    logic [4:0]        lz;
    logic              found, sticky, round_up;
    logic [24:0]       rnd;
    logic signed [9:0] e_n, e_fin;

    always_comb begin
        // x holds the operand of larger magnitude, so the result takes its sign
        if (a_i[30:0] >= b_i[30:0]) begin
            x = a_i;
            y = b_i;
        end else begin
            x = b_i;
            y = a_i;
        end
        ex    = x[30:23];
        ey    = y[30:23];
        mx    = (ex == 8'd0) ? '0 : {1'b1, x[22:0], 3'b000};
        my    = (ey == 8'd0) ? '0 : {1'b1, y[22:0], 3'b000};
        d_exp = ex - ey;
        if (d_exp > 8'd26) begin
            my_sh  = '0;
            sticky = |my;
        end else begin
            my_sh  = my >> d_exp;
            sticky = |(my & ((27'd1 << d_exp) - 27'd1));
        end
        my_sh[0] = my_sh[0] | sticky;
        raw = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});

        lz    = '0;
        found = 1'b0;
        for (int k = 26; k >= 0; k--) begin
            if (!found && raw[k]) begin
                lz    = 5'(26 - k);
                found = 1'b1;
            end
        end
        if (raw[27]) begin
            nrm = {raw[27:2], raw[1] | raw[0]};
            e_n = $signed({2'b00, ex}) + 10'sd1;
        end else begin
            nrm = raw[26:0] << lz;
            e_n = $signed({2'b00, ex}) - $signed({5'b00000, lz});
        end

        round_up = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        rnd      = {1'b0, nrm[26:3]} + {24'd0, round_up};
        e_fin    = e_n + $signed({9'd0, rnd[24]});

        of_o = 1'b0;
        if (raw == '0) begin
            sum_o = {x[31] & y[31], 31'd0};
        end else if (e_fin >= 10'sd255) begin
            sum_o = {x[31], 8'hFF, 23'd0};
            of_o  = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            sum_o = {x[31], 31'd0};
        end else begin
            sum_o = {x[31], e_fin[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
        end
    end
endmodule

// File: rtl/fpa_scheduler_rr_arbiter.sv
// Round-robin arbiter: search begins one past the last grant; the pointer moves only on accept.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  elig_i,
    input  logic          accept_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        // Walk farthest-first so the nearest eligible requester overwrites earlier picks.
        for (int off = N; off >= 1; off--) begin
            idx = (int'(ptr_q) + off) % N;
            if (elig_i[IW'(idx)]) begin
                grant_o              = '0;
                grant_o[IW'(idx)]    = 1'b1;
                grant_idx_o          = IW'(idx);
            end
        end
        ptr_d = accept_i ? grant_idx_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= IW'(N - 1);
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/fpa_scheduler.sv
// Shares one FP adder among NREQ requesters through a 2-stage pipeline with per-requester result slots.
// Define FPA_SCHED_STATS_EN to add the stat_ops / stat_of saturating counters.
module fpa_scheduler
    import fpa_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*FP_W-1:0] rsp_data,
    output logic [NREQ-1:0]      rsp_of,
    input  logic [NREQ-1:0]      rsp_ack,
    output logic                 busy
`ifdef FPA_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_ops,
    output logic [STAT_W-1:0]    stat_of
`endif
);
    logic [NREQ-1:0]  elig, grant, busy_vec;
    logic [TAG_W-1:0] grant_idx;
    logic             accept;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic [FP_W-1:0]  sum;
    logic             sum_of;
    slot_state_e      slot_q [NREQ];
    slot_state_e      slot_d [NREQ];
    logic [FP_W-1:0]  data_q [NREQ];
    logic [FP_W-1:0]  data_d [NREQ];
    logic [NREQ-1:0]  of_q, of_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot_io
            // Gating with reset keeps req_ready low while reset is held.
            assign elig[gi]                    = reset && req_valid[gi] && (slot_q[gi] == SLOT_IDLE);
            assign busy_vec[gi]                = (slot_q[gi] != SLOT_IDLE);
            assign rsp_valid[gi]               = (slot_q[gi] == SLOT_DONE);
            assign rsp_data[gi*FP_W +: FP_W]   = data_q[gi];
            assign rsp_of[gi]                  = of_q[gi];
        end
    endgenerate

    assign req_ready = grant;
    assign accept    = |grant;
    assign busy      = |busy_vec;

    rr_arbiter #(.N(NREQ), .IW(TAG_W)) u_arb (
        .clk         (clk),
        .rst_n       (reset),
        .elig_i      (elig),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.valid = accept;
        s1_d.tag   = TAG_MAX_W'(grant_idx);
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                s1_d.a = req_a[i*FP_W +: FP_W];
                s1_d.b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    fpa u_fpa (
        .a_i   (s1_q.a),
        .b_i   (s1_q.b),
        .sum_o (sum),
        .of_o  (sum_of)
    );

    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.tag   = s1_q.tag;
        s2_d.sum   = sum;
        s2_d.of    = sum_of;
    end

    // Write-back only ever targets a BUSY slot, so it cannot clash with an ack of a DONE slot.
    always_comb begin
        slot_d = slot_q;
        data_d = data_q;
        of_d   = of_q;
        for (int i = 0; i < NREQ; i++) begin
            case (slot_q[i])
                SLOT_IDLE: if (grant[i]) slot_d[i] = SLOT_BUSY;
                SLOT_BUSY: if (s2_q.valid && (s2_q.tag == TAG_MAX_W'(i))) begin
                    slot_d[i] = SLOT_DONE;
                    data_d[i] = s2_q.sum;
                    of_d[i]   = s2_q.of;
                end
                SLOT_DONE: if (rsp_ack[i]) slot_d[i] = SLOT_IDLE;
                default:   slot_d[i] = SLOT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            of_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= SLOT_IDLE;
                data_q[i] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            of_q   <= of_d;
            slot_q <= slot_d;
            data_q <= data_d;
        end
    end

`ifdef FPA_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_ops_q, stat_of_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ops_q <= '0;
            stat_of_q  <= '0;
        end else begin
            if (accept && (stat_ops_q != '1))
                stat_ops_q <= stat_ops_q + 1'b1;
            if (s2_q.valid && s2_q.of && (stat_of_q != '1))
                stat_of_q <= stat_of_q + 1'b1;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_of  = stat_of_q;
`endif
endmodule
